// File: rtl/mips_pkg.sv
// Shared datapath definitions for the MIPS core: widths, register indices, word types.
// Ports: none (package).
// Imported by the register file, ALU, ALU control and RegDst mux.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_AT   = 5'd1;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bundle: two operand read ports, one write-back port, one debug read port.
// Ports: rs/rt/dbg address+data pairs, wr_en/wr_addr/wr_data.
// master = decode/write-back side (drives indices and write data); slave = register file.
interface reg_file_if;
  import mips_pkg::*;

  reg_idx_t rs_addr;
  reg_idx_t rt_addr;
  word_t    rs_data;
  word_t    rt_data;
  logic     wr_en;
  reg_idx_t wr_addr;
  word_t    wr_data;
  reg_idx_t dbg_addr;
  word_t    dbg_data;

  modport master (
    output rs_addr, rt_addr, wr_en, wr_addr, wr_data, dbg_addr,
    input  rs_data, rt_data, dbg_data
  );

  modport slave (
    input  rs_addr, rt_addr, wr_en, wr_addr, wr_data, dbg_addr,
    output rs_data, rt_data, dbg_data
  );

endinterface

// File: rtl/reg_file_cell.sv
// One architectural register: W-bit storage with async active-low clear and load enable.
// Ports: clk, rst_n, en (load strobe), d (next value), q (stored value).
// q changes only on the rising clk edge when en=1, or immediately when rst_n falls.
module reg_cell #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32 x 32 MIPS general-purpose register file, $0 hardwired to zero, no write bypass.
// Ports: clk, rst_n (async active-low clear), bus (reg_file_if.slave: rs/rt/dbg reads, write-back).
// Reads are combinational; a write becomes visible on the read ports after the rising clk edge.
module reg_file #(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int ADDR_W   = mips_pkg::ADDR_W,
  parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_file_if.slave  bus
);
  import mips_pkg::*;

  // Per-register write strobes; $0 has no storage so there is no bit 0.
  logic [NUM_REGS-1:1] wr_sel;
  logic [DATA_W-1:0]   cell_q [1:NUM_REGS-1];
  logic [DATA_W-1:0]   regs   [NUM_REGS];

  // The strobe is raised only when wr_en is exactly 1: an X on wr_en or
  // wr_addr leaves the if-condition false/X and no cell sees a load.
  always_comb begin
    wr_sel = '0;
    if (bus.wr_en == 1'b1) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        wr_sel[i] = (bus.wr_addr == ADDR_W'(i));
      end
    end
  end

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cell
    reg_cell #(.W(DATA_W)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (wr_sel[g]),
      .d     (bus.wr_data),
      .q     (cell_q[g])
    );
  end

  // Read view of the architectural state, with index 0 forced to zero.
  always_comb begin
    regs[REG_ZERO] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      regs[i] = cell_q[i];
    end
  end

  assign bus.rs_data  = regs[bus.rs_addr];
  assign bus.rt_data  = regs[bus.rt_addr];
  assign bus.dbg_data = regs[bus.dbg_addr];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table plus reset / ALU-handoff sequences.
// Ports: none (top-level bench).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after that.
module tb_reg_file;
  import mips_pkg::*;

  logic clk;
  logic rst_n;

  reg_file_if bus ();

  reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  typedef struct {
    logic     we;
    reg_idx_t wa;
    word_t    wd;
    reg_idx_t rs;
    reg_idx_t rt;
    reg_idx_t dbg;
    word_t    exp_rs;
    word_t    exp_rt;
    word_t    exp_dbg;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic we, input reg_idx_t wa, input word_t wd,
                              input reg_idx_t rs, input reg_idx_t rt, input reg_idx_t dbg,
                              input word_t ers, input word_t ert, input word_t edbg);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd;
    v.rs = rs; v.rt = rt; v.dbg = dbg;
    v.exp_rs = ers; v.exp_rt = ert; v.exp_dbg = edbg;
    return v;
  endfunction

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.dbg_addr = reg_idx_t'(i);
      #1;
      check($sformatf("%s_dbg%0d", tag, i), bus.dbg_data, 32'h0);
    end
  endtask

  initial begin
    word_t diff;
    n_checks = 0;
    n_fail   = 0;

    // Vectors: inputs applied, pre-edge reads checked, then one clock edge commits the write.
    vecs[0]  = mk(1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  5'd0,  32'h0,        32'h0,        32'h0);
    vecs[1]  = mk(1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd4,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
    vecs[2]  = mk(1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  5'd6,  32'h0,        32'hDEADBEEF, 32'h0);
    vecs[3]  = mk(1'b0, 5'd0,  32'h0,        5'd0,  5'd4,  5'd5,  32'h0,        32'h0,        32'hDEADBEEF);
    vecs[4]  = mk(1'b1, 5'd7,  32'h11111111, 5'd7,  5'd0,  5'd7,  32'h0,        32'h0,        32'h0);
    vecs[5]  = mk(1'b1, 5'd7,  32'h22222222, 5'd7,  5'd7,  5'd5,  32'h11111111, 32'h11111111, 32'hDEADBEEF);
    vecs[6]  = mk(1'b0, 5'd9,  32'hA5A5A5A5, 5'd7,  5'd9,  5'd7,  32'h22222222, 32'h0,        32'h22222222);
    vecs[7]  = mk(1'b0, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd9,  5'd9,  32'h0,        32'h0,        32'h0);
    vecs[8]  = mk(1'b0, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd9,  5'd9,  32'h0,        32'h0,        32'h0);
    vecs[9]  = mk(1'b0, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd9,  5'd9,  32'h0,        32'h0,        32'h0);
    vecs[10] = mk(1'b1, 5'd31, 32'h80000001, 5'd31, 5'd29, 5'd31, 32'h0,        32'h0,        32'h0);
    vecs[11] = mk(1'b1, 5'd29, 32'h0000FFFF, 5'd31, 5'd29, 5'd1,  32'h80000001, 32'h0,        32'h0);
    vecs[12] = mk(1'b1, 5'd1,  32'h00000007, 5'd29, 5'd31, 5'd1,  32'h0000FFFF, 32'h80000001, 32'h0);
    vecs[13] = mk(1'b1, 5'd2,  32'h00000003, 5'd1,  5'd2,  5'd2,  32'h7,        32'h0,        32'h0);
    vecs[14] = mk(1'b0, 5'd0,  32'h0,        5'd1,  5'd2,  5'd2,  32'h7,        32'h3,        32'h3);

    rst_n        = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rs_addr  = '0;
    bus.rt_addr  = '0;
    bus.dbg_addr = '0;

    // Reset state, then a write attempted across an edge while reset is held.
    #1;
    sweep_zero("rst_init");
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd5;
    bus.wr_data = 32'h12345678;
    @(posedge clk); #1;
    bus.dbg_addr = 5'd5;
    #1;
    check("rst_hold_write", bus.dbg_data, 32'h0);
    bus.wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < NV; v++) begin
      bus.wr_en    = vecs[v].we;
      bus.wr_addr  = vecs[v].wa;
      bus.wr_data  = vecs[v].wd;
      bus.rs_addr  = vecs[v].rs;
      bus.rt_addr  = vecs[v].rt;
      bus.dbg_addr = vecs[v].dbg;
      #1;
      check($sformatf("vec%0d_rs", v),  bus.rs_data,  vecs[v].exp_rs);
      check($sformatf("vec%0d_rt", v),  bus.rt_data,  vecs[v].exp_rt);
      check($sformatf("vec%0d_dbg", v), bus.dbg_data, vecs[v].exp_dbg);
      @(posedge clk); #1;
    end

    // ALU handoff: operand A - operand B as the ALU's SUB would see it.
    bus.wr_en   = 1'b0;
    bus.rs_addr = 5'd1;
    bus.rt_addr = 5'd2;
    #1;
    diff = bus.rs_data - bus.rt_data;
    check("alu_sub_7_3", diff, 32'd4);
    check("alu_z_7_3", {31'b0, diff == 32'd0}, 32'd0);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd2;
    bus.wr_data = 32'd7;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    #1;
    diff = bus.rs_data - bus.rt_data;
    check("alu_sub_7_7", diff, 32'd0);
    check("alu_z_7_7", {31'b0, diff == 32'd0}, 32'd1);

    // Load every register with a distinct nonzero value and read it all back.
    for (int i = 1; i < NUM_REGS; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = reg_idx_t'(i);
      bus.wr_data = 32'hC0DE0000 | word_t'(i);
      @(posedge clk); #1;
    end
    bus.wr_en = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.dbg_addr = reg_idx_t'(i);
      #1;
      check($sformatf("load_dbg%0d", i), bus.dbg_data,
            (i == 0) ? 32'h0 : (32'hC0DE0000 | word_t'(i)));
    end

    // Mid-cycle reset during an active write: everything reads 0 at once.
    @(posedge clk); #2;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd3;
    bus.wr_data = 32'hFFFF0000;
    bus.rs_addr = 5'd3;
    bus.rt_addr = 5'd31;
    rst_n = 1'b0;
    #1;
    check("midrst_rs", bus.rs_data, 32'h0);
    check("midrst_rt", bus.rt_data, 32'h0);
    sweep_zero("midrst");

    // First write after release lands on the first rising edge.
    @(negedge clk);
    rst_n       = 1'b1;
    bus.wr_addr = 5'd3;
    bus.wr_data = 32'h12345678;
    bus.dbg_addr = 5'd3;
    #1;
    check("post_rst_pre_edge", bus.dbg_data, 32'h0);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    check("post_rst_first_write", bus.dbg_data, 32'h12345678);
    check("post_rst_other", bus.rt_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
